// File: rtl/cpu_pkg.sv
// Types and constants shared between the fetch unit and its entry FIFO.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; a flush may carry one push,
// which becomes the only entry.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      if (push) begin
        mem[0] <= push_data;
        wr_ptr <= AW'(1);
        count  <= CW'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, credit-limited pipelined imem requests, redirect/halt.
// Define IFU_MISALIGN_CHK_EN to turn misaligned redirects into a faulting nop entry.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        inst_misalign
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc, resp_pc, redirect_base;
  logic [CW-1:0]   outstanding, drop_cnt, fifo_count;
  logic [CW:0]     credit_used;
  logic            fifo_full, fifo_empty;
  logic            req_fire, resp_keep, push, redirect_bad, misalign_hold;
  fetch_entry_t    push_entry, head;

`ifdef IFU_MISALIGN_CHK_EN
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_bad = 1'b0;
`endif

  assign redirect_base  = redirect_pc & 32'hFFFF_FFFC;
  // Words in flight plus words buffered may never exceed the FIFO depth.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = (state == FETCH) && !halt && !redirect_valid &&
                          (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_keep      = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
  assign push           = resp_keep || redirect_bad;

  always_comb begin
    push_entry = '{inst: imem_resp_data, pc: resp_pc, misalign: 1'b0};
    if (redirect_bad) push_entry = '{inst: NOP_INST, pc: redirect_pc, misalign: 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      resp_pc       <= RESET_PC;
      outstanding   <= '0;
      drop_cnt      <= '0;
      misalign_hold <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        // Everything still in flight belongs to the old stream and is discarded on return.
        fetch_pc      <= redirect_base;
        resp_pc       <= redirect_base;
        drop_cnt      <= outstanding - CW'(imem_resp_valid);
        misalign_hold <= redirect_bad;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (resp_keep) resp_pc <= resp_pc + 32'd4;
        if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
      if (redirect_bad) state <= HALTED;
      else begin
        case (state)
          IDLE:    state <= FETCH;
          FETCH:   if (halt) state <= HALTED;
          HALTED:  if (redirect_valid || (!halt && !misalign_hold)) state <= FETCH;
          default: state <= IDLE;
        endcase
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (inst_valid && inst_ready),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign inst_valid    = !fifo_empty;
  assign inst          = head.inst;
  assign inst_pc       = head.pc;
  assign inst_misalign = head.misalign;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: in-order variable-latency imem model,
// logs of accepted requests and delivered instructions, hand-computed expectations.
module tb_inst_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0, reset = 1'b1;
  logic        redirect_valid = 1'b0, halt = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid, inst_ready = 1'b0, inst_misalign;
  logic [31:0] inst, inst_pc;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t        mq[$];
  logic [31:0]  req_log[$];
  fetch_entry_t del_log[$];
  int cyc = 0, lat = 1, n_vec = 0, n_err = 0;

  inst_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .inst_misalign(inst_misalign)
  );

  always #5 clk = ~clk;

  // Memory word at address a is a ^ 32'hDEAD_0000.
  always @(negedge clk) begin
    #1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (reset) mq.delete();
    else begin
      if (mq.size() > 0 && mq[0].due == cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mq[0].addr ^ 32'hDEAD_0000;
        void'(mq.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{imem_req_addr, cyc + lat});
        req_log.push_back(imem_req_addr);
      end
      if (inst_valid && inst_ready) del_log.push_back('{inst, inst_pc, inst_misalign});
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic do_reset(input int l);
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; halt = 1'b0; inst_ready = 1'b0;
    imem_req_ready = 1'b1; lat = l;
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    req_log.delete();
    del_log.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int t;
    int n;
    // Reset state
    @(negedge clk); #2;
    chk("rst_req_valid0", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid0", 32'(inst_valid), 32'd0);
    chk("rst_inst0", inst, 32'h0);
    chk("rst_inst_pc0", inst_pc, 32'h0);
    chk("rst_misalign0", 32'(inst_misalign), 32'd0);

    // T1: latency 1, decode always ready
    do_reset(1);
    inst_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #2;
      chk("t1_inst_valid", 32'(inst_valid), 32'(k == 3));
      if (k == 1) chk("t1_first_addr", imem_req_addr, 32'h0);
    end
    chk("t1_inst_pc", inst_pc, 32'h0);
    chk("t1_inst", inst, 32'hDEAD_0000);
    repeat (6) @(negedge clk);
    #2;
    chk("t1_deliv_cnt", 32'(del_log.size()), 32'd7);
    for (int i = 0; i < 7; i++) chk("t1_deliv_pc", del_log[i].pc, 32'(i * 4));
    chk("t1_req4", req_log[4], 32'h10);
    chk("t1_inst6", del_log[6].inst, 32'hDEAD_0018);

    // T2: decode stalled, latency 2 -> credits stop issue at DEPTH
    do_reset(2);
    repeat (12) @(negedge clk);
    #2;
    chk("t2_req_cnt", 32'(req_log.size()), 32'd4);
    chk("t2_req3", req_log[3], 32'hC);
    chk("t2_no_req", 32'(imem_req_valid), 32'd0);
    chk("t2_head_pc", inst_pc, 32'h0);
    @(negedge clk); inst_ready = 1'b1;
    @(negedge clk); inst_ready = 1'b0;
    #2;
    chk("t2_resume_valid", 32'(imem_req_valid), 32'd1);
    chk("t2_resume_addr", imem_req_addr, 32'h10);
    @(negedge clk); inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    chk("t2_pc1", del_log[1].pc, 32'h4);
    chk("t2_pc3", del_log[3].pc, 32'hC);
    chk("t2_pc4", del_log[4].pc, 32'h10);

    // T3: redirect with 3 requests in flight
    do_reset(4);
    inst_ready = 1'b1;
    t = 0;
    while (req_log.size() < 3 && t < 40) begin @(negedge clk); #2; t++; end
    chk("t3_inflight", 32'(req_log.size()), 32'd3);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100;
    #2;
    chk("t3_gated", 32'(imem_req_valid), 32'd0);
    @(negedge clk); redirect_valid = 1'b0;
    repeat (15) @(negedge clk);
    #2;
    chk("t3_req_after", req_log[3], 32'h100);
    chk("t3_first_pc", del_log[0].pc, 32'h100);
    chk("t3_first_inst", del_log[0].inst, 32'hDEAD_0100);
    chk("t3_second_pc", del_log[1].pc, 32'h104);

    // T4: memory not ready for 5 cycles
    do_reset(1);
    imem_req_ready = 1'b0; inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      chk("t4_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("t4_hold_addr", imem_req_addr, 32'h0);
    end
    @(negedge clk); imem_req_ready = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    chk("t4_req0", req_log[0], 32'h0);
    chk("t4_req1", req_log[1], 32'h4);
    chk("t4_deliv0", del_log[0].pc, 32'h0);

    // T5: halt with 2 in flight, then redirect
    do_reset(3);
    inst_ready = 1'b1;
    t = 0;
    while (req_log.size() < 2 && t < 40) begin @(negedge clk); #2; t++; end
    @(negedge clk); halt = 1'b1;
    #2;
    chk("t5_halt_gate", 32'(imem_req_valid), 32'd0);
    repeat (10) @(negedge clk);
    #2;
    chk("t5_req_cnt", 32'(req_log.size()), 32'd2);
    chk("t5_deliv_cnt", 32'(del_log.size()), 32'd2);
    chk("t5_deliv1", del_log[1].pc, 32'h4);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h40; halt = 1'b0;
    @(negedge clk); redirect_valid = 1'b0;
    #2;
    chk("t5_resume_valid", 32'(imem_req_valid), 32'd1);
    chk("t5_resume_addr", imem_req_addr, 32'h40);

    // T6: misaligned redirect
    do_reset(1);
    repeat (8) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk); redirect_valid = 1'b0;
    #2;
    n = req_log.size();
`ifdef IFU_MISALIGN_CHK_EN
    chk("t6_valid", 32'(inst_valid), 32'd1);
    chk("t6_inst", inst, 32'h13);
    chk("t6_pc", inst_pc, 32'h102);
    chk("t6_misalign", 32'(inst_misalign), 32'd1);
    repeat (5) @(negedge clk);
    #2;
    chk("t6_no_req", 32'(imem_req_valid), 32'd0);
    chk("t6_req_cnt", 32'(req_log.size()), 32'(n));
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk); redirect_valid = 1'b0;
    #2;
    chk("t6_resume_valid", 32'(imem_req_valid), 32'd1);
    chk("t6_resume_addr", imem_req_addr, 32'h200);
    chk("t6_flushed", 32'(inst_valid), 32'd0);
`else
    chk("t6_flushed", 32'(inst_valid), 32'd0);
    chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t6_req_addr", imem_req_addr, 32'h100);
    @(negedge clk); inst_ready = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    chk("t6_deliv_pc", del_log[0].pc, 32'h100);
    chk("t6_deliv_inst", del_log[0].inst, 32'hDEAD_0100);
    chk("t6_misalign", 32'(del_log[0].misalign), 32'd0);
`endif

    // T7: PC wrap, redirect coinciding with a returning response
    do_reset(1);
    inst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk); redirect_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    chk("t7_req1", req_log[1], 32'hFFFF_FFF8);
    chk("t7_req2", req_log[2], 32'hFFFF_FFFC);
    chk("t7_req3", req_log[3], 32'h0);
    chk("t7_deliv0", del_log[0].pc, 32'hFFFF_FFF8);
    chk("t7_deliv2_pc", del_log[2].pc, 32'h0);
    chk("t7_deliv2_inst", del_log[2].inst, 32'hDEAD_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
